// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - in-order instruction fetch buffer with redirect flush and late-response discard
module ifetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [AW-1:0]    alloc_ptr, fill_ptr, rd_ptr;
    logic [AW:0]      alloc_cnt, discard_cnt;

    logic [AW-1:0]    ptr_diff;
    logic [AW:0]      outstanding, pending, flush_discard;
    logic             do_push, do_fill, do_pop, do_drop;

    // Equal alloc/fill pointers mean either nothing or everything is in flight;
    // a full buffer whose head is still unfilled can only be the latter.
    always_comb begin
        ptr_diff = alloc_ptr - fill_ptr;
        if (ptr_diff == '0 && alloc_cnt == FULL && !filled_q[rd_ptr])
            outstanding = FULL;
        else
            outstanding = {1'b0, ptr_diff};
        pending       = discard_cnt + outstanding;
        flush_discard = (imem_rvalid_i && pending != '0) ? pending - CNT_ONE : pending;
    end

    assign imem_req_o   = rst && pc_valid_i && !flush_i && (alloc_cnt < FULL) && (discard_cnt == '0);
    assign pc_ready_o   = imem_req_o && imem_gnt_i;
    assign imem_addr_o  = pc_i;
    assign inst_valid_o = (alloc_cnt != '0) && filled_q[rd_ptr];
    assign inst_o       = inst_q[rd_ptr];
    assign inst_pc_o    = pc_q[rd_ptr];

    assign do_push = pc_ready_o;
    assign do_pop  = inst_valid_o && inst_ready_i && !flush_i;
    assign do_drop = imem_rvalid_i && (discard_cnt != '0);
    assign do_fill = imem_rvalid_i && (discard_cnt == '0) && (outstanding != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            alloc_cnt   <= '0;
            discard_cnt <= '0;
            filled_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
        end else if (flush_i) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            alloc_cnt   <= '0;
            filled_q    <= '0;
            discard_cnt <= flush_discard;
        end else begin
            if (do_drop)
                discard_cnt <= discard_cnt - CNT_ONE;
            if (do_push) begin
                pc_q[alloc_ptr]     <= pc_i;
                filled_q[alloc_ptr] <= 1'b0;
                alloc_ptr           <= alloc_ptr + PTR_ONE;
            end
            if (do_fill) begin
                inst_q[fill_ptr]   <= imem_rdata_i;
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + PTR_ONE;
            end
            if (do_pop) begin
                filled_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop)
                alloc_cnt <= alloc_cnt + CNT_ONE;
            else if (!do_push && do_pop)
                alloc_cnt <= alloc_cnt - CNT_ONE;
        end
    end
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb/tb_ifetch_buffer.sv - self-checking bench for ifetch_buffer against a queue-based fetch model
module tb_ifetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_ready_i = 1'b0;
    logic        pc_ready_o, imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, inst_pc_o;

    ifetch_buffer #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] pc; int due; } mreq_t;

    // Model: filled words waiting for decode, then PCs still in flight, then responses owed to a flush.
    ent_t        m_rdy[$];
    logic [31:0] m_pend[$];
    int          m_disc = 0;
    logic [31:0] seen[$];
    mreq_t       memq[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0013;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int  outs, p;
        bit  v, req;
        if (!rst) begin
            m_rdy.delete();
            m_pend.delete();
            m_disc = 0;
        end else begin
            outs = m_pend.size();
            v    = m_rdy.size() != 0;
            req  = pc_valid_i && !flush_i && (m_rdy.size() + outs < DEPTH) && (m_disc == 0);
            if (flush_i) begin
                p = m_disc + outs;
                if (imem_rvalid_i && p > 0) p--;
                m_disc = p;
                m_rdy.delete();
                m_pend.delete();
            end else begin
                if (v && inst_ready_i) void'(m_rdy.pop_front());
                if (m_disc > 0) begin
                    if (imem_rvalid_i) m_disc--;
                end else if (imem_rvalid_i && outs > 0) begin
                    m_rdy.push_back('{pc: m_pend[0], inst: imem_rdata_i});
                    void'(m_pend.pop_front());
                end
                if (req && imem_gnt_i) m_pend.push_back(pc_i);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ev, er;
        ev = rst && (m_rdy.size() != 0);
        er = rst && pc_valid_i && !flush_i && (m_rdy.size() + m_pend.size() < DEPTH) && (m_disc == 0);
        chk("imem_req", 32'(imem_req_o), 32'(er));
        chk("pc_ready", 32'(pc_ready_o), 32'(er && imem_gnt_i));
        chk("inst_valid", 32'(inst_valid_o), 32'(ev));
        if (er) chk("imem_addr", imem_addr_o, pc_i);
        if (ev) begin
            chk("inst", inst_o, m_rdy[0].inst);
            chk("inst_pc", inst_pc_o, m_rdy[0].pc);
        end
        if (inst_valid_o && inst_ready_i && !flush_i) seen.push_back(inst_pc_o);
    end

    task automatic cy(input bit pv, input logic [31:0] pc, input bit g, input bit rv,
                      input logic [31:0] rd, input bit rdy, input bit fl);
        @(posedge clk);
        #1;
        pc_valid_i    = pv;
        pc_i          = pc;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        inst_ready_i  = rdy;
        flush_i       = fl;
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cy(0, 32'h0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic chk_seen(input string name, input int n, input logic [31:0] base);
        chk({name, " count"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++) chk(name, seen[i], base + 32'(4 * i));
        seen.delete();
    endtask

    initial begin : stim
        int issued, gw;
        // reset held with a pending fetch request
        cy(1, 32'h0, 1, 0, 32'h0, 0, 0);
        chk("rst imem_req", 32'(imem_req_o), 32'h0);
        chk("rst pc_ready", 32'(pc_ready_o), 32'h0);
        chk("rst inst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst inst", inst_o, 32'h0);
        cy(1, 32'h0, 1, 0, 32'h0, 0, 0);
        chk("rst inst_pc", inst_pc_o, 32'h0);
        idle(1);
        rst = 1'b1;
        idle(1);

        // single fetch, two-cycle latency, no bypass
        cy(1, 32'h0, 1, 0, 32'h0, 0, 0);
        chk("t2 req", 32'(imem_req_o), 32'h1);
        cy(0, 32'h0, 0, 1, 32'h0050_0093, 0, 0);
        chk("t2 no bypass", 32'(inst_valid_o), 32'h0);
        cy(0, 32'h0, 0, 0, 32'h0, 1, 0);
        chk("t2 valid", 32'(inst_valid_o), 32'h1);
        chk("t2 inst", inst_o, 32'h0050_0093);
        chk("t2 inst_pc", inst_pc_o, 32'h0);
        idle(1);
        chk("t2 popped", 32'(inst_valid_o), 32'h0);
        chk_seen("t2 order", 1, 32'h0);

        // fill to DEPTH, full blocks even with same-cycle pop
        cy(1, 32'h0, 1, 0, 32'h0, 0, 0);
        cy(1, 32'h4, 1, 1, word(32'h0), 0, 0);
        cy(1, 32'h8, 1, 1, word(32'h4), 0, 0);
        cy(1, 32'hC, 1, 1, word(32'h8), 0, 0);
        cy(1, 32'h10, 1, 1, word(32'hC), 0, 0);
        chk("t3 full req", 32'(imem_req_o), 32'h0);
        cy(1, 32'h10, 1, 0, 32'h0, 1, 0);
        chk("t3 full+pop req", 32'(imem_req_o), 32'h0);
        chk("t3 head inst", inst_o, word(32'h0));
        cy(1, 32'h10, 1, 0, 32'h0, 0, 0);
        chk("t3 req after pop", 32'(imem_req_o), 32'h1);
        cy(0, 32'h0, 0, 1, word(32'h10), 1, 0);
        for (int i = 0; i < 4; i++) cy(0, 32'h0, 0, 0, 32'h0, 1, 0);
        idle(1);
        chk_seen("t3 order", 5, 32'h0);

        // flush with two fetches in flight
        cy(1, 32'h40, 1, 0, 32'h0, 0, 0);
        cy(1, 32'h44, 1, 1, word(32'h40), 0, 0);
        cy(1, 32'h48, 1, 0, 32'h0, 0, 0);
        cy(0, 32'h0, 0, 0, 32'h0, 0, 1);
        cy(1, 32'h80, 1, 0, 32'h0, 0, 0);
        chk("t4 flushed valid", 32'(inst_valid_o), 32'h0);
        chk("t4 blocked 0", 32'(imem_req_o), 32'h0);
        cy(1, 32'h80, 1, 1, 32'hDEAD_0001, 0, 0);
        chk("t4 blocked 1", 32'(imem_req_o), 32'h0);
        cy(1, 32'h80, 1, 1, 32'hDEAD_0002, 0, 0);
        chk("t4 blocked 2", 32'(imem_req_o), 32'h0);
        cy(1, 32'h80, 1, 0, 32'h0, 0, 0);
        chk("t4 req resumes", 32'(imem_req_o), 32'h1);
        cy(0, 32'h0, 0, 1, word(32'h80), 0, 0);
        cy(0, 32'h0, 0, 0, 32'h0, 1, 0);
        chk("t4 inst_pc", inst_pc_o, 32'h80);
        chk("t4 inst", inst_o, word(32'h80));
        idle(1);
        chk_seen("t4 order", 1, 32'h80);

        // flush coinciding with a response
        cy(1, 32'h100, 1, 0, 32'h0, 0, 0);
        cy(1, 32'h104, 1, 0, 32'h0, 0, 0);
        cy(0, 32'h0, 0, 1, 32'hDEAD_0003, 0, 1);
        cy(1, 32'h200, 1, 0, 32'h0, 0, 0);
        chk("t5 blocked 0", 32'(imem_req_o), 32'h0);
        cy(1, 32'h200, 1, 1, 32'hDEAD_0004, 0, 0);
        chk("t5 blocked 1", 32'(imem_req_o), 32'h0);
        cy(1, 32'h200, 1, 0, 32'h0, 0, 0);
        chk("t5 req resumes", 32'(imem_req_o), 32'h1);
        cy(0, 32'h0, 0, 1, word(32'h200), 0, 0);
        cy(0, 32'h0, 0, 0, 32'h0, 1, 0);
        chk("t5 inst_pc", inst_pc_o, 32'h200);
        idle(1);
        chk_seen("t5 order", 1, 32'h200);

        // randomised grant/response delays and decode backpressure over 64 PCs
        issued = 0;
        gw = 0;
        for (int t = 0; t < 3000 && seen.size() < 64; t++) begin
            @(posedge clk);
            #1;
            pc_valid_i = (issued < 64);
            pc_i       = 32'h1000 + 32'(4 * issued);
            imem_gnt_i = (gw == 0);
            flush_i    = 1'b0;
            if (memq.size() > 0 && memq[0].due <= t) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = word(memq[0].pc);
                void'(memq.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end
            inst_ready_i = ($urandom_range(0, 2) != 0);
            #1;
            if (pc_ready_o) begin
                memq.push_back('{pc: pc_i, due: t + 1 + int'($urandom_range(0, 3))});
                issued++;
                gw = int'($urandom_range(0, 3));
            end else if (gw > 0) begin
                gw--;
            end
        end
        idle(1);
        chk_seen("t6 order", 64, 32'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
